// File: rtl/seq_slice_comparator.sv
// Sequential MSB-first slice comparator with eq/gt cascade inputs, signed mode and early exit.
// Latency: k CMP cycles (k = slices examined, 1..N) plus one FIN cycle with the done pulse.
// Backpressure: start is accepted only in IDLE; requests while busy or in FIN are dropped.
module seq_slice_comparator #(
    parameter int W = 32,
    parameter int S = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        signed_mode,
    input  logic [W-1:0]                A,
    input  logic [W-1:0]                B,
    input  logic                        eq,
    input  logic                        gt,
    output logic                        busy,
    output logic                        done,
    output logic                        EQ,
    output logic                        GT,
    output logic [$clog2(W/S+1)-1:0]    slices
);

    localparam int N  = W / S;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

    state_t          state, state_n;
    logic [W-1:0]    a_q, b_q;
    logic            eq_q, gt_q, sgn_q;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   count;

    logic [S-1:0]    a_sl, b_sl;
    logic            a_gt, a_lt, last_sl, decide;

    assign a_sl    = a_q[idx*S +: S];
    assign b_sl    = b_q[idx*S +: S];
    assign last_sl = (idx == '0);

    // Only the top slice carries the sign bit; lower slices are magnitude bits.
    always_comb begin
        a_gt = 1'b0;
        a_lt = 1'b0;
        if (sgn_q && idx == IW'(N - 1)) begin
            a_gt = $signed(a_sl) > $signed(b_sl);
            a_lt = $signed(a_sl) < $signed(b_sl);
        end else begin
            a_gt = a_sl > b_sl;
            a_lt = a_sl < b_sl;
        end
    end

    assign decide = a_gt || a_lt || last_sl;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CMP;
            CMP:     if (decide) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            eq_q   <= 1'b0;
            gt_q   <= 1'b0;
            sgn_q  <= 1'b0;
            idx    <= '0;
            count  <= '0;
            EQ     <= 1'b0;
            GT     <= 1'b0;
            slices <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_q   <= A;
                b_q   <= B;
                eq_q  <= eq;
                gt_q  <= gt;
                sgn_q <= signed_mode;
                idx   <= IW'(N - 1);
                count <= '0;
            end
            if (state == CMP) begin
                count <= count + CW'(1);
                if (decide) begin
                    EQ     <= (a_gt || a_lt) ? 1'b0 : eq_q;
                    GT     <= a_gt ? 1'b1 : (a_lt ? 1'b0 : gt_q);
                    slices <= count + CW'(1);
                end else begin
                    idx <= idx - IW'(1);
                end
            end
        end
    end

    assign busy = (state == CMP);
    assign done = (state == FIN);

endmodule
